bcd_convert_seq: RTL and testbench

Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between the CPU register outputs (AX/DX, zero-extended) and the seven-segment scan driver. It replaces the combinational 16-bit converter and cuts logic depth on the display path. The result register holds the last completed conversion, so the display never sees intermediate values.

---
 rtl/bcd_convert_seq.sv | 89 ++++++++
 tb/tb_bcd_convert_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Sits between the CPU register outputs and the seven-segment scan driver.
// The result register only updates when a conversion completes, so the
// display never shows intermediate values.
//
// Ports:
//   clk    - system clock, rising edge
//   RESET  - synchronous, active-high reset
//   start  - conversion request, only sampled while idle
//   bin    - unsigned binary operand, captured when start is accepted
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd has just been updated
//   bcd    - packed BCD result, digit k = bcd[4k+3:4k], digit 0 = units
module bcd_convert_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SH_W  = BCD_W + WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t            state;
  logic [SH_W-1:0]   sh;        // {scratch, bin_sh}
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   corrected;
  logic [SH_W-1:0]   shifted;

  // Add 3 to every scratch digit >= 5, then shift the whole register left.
  always_comb begin
    corrected = sh;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (sh[WIDTH + 4*k +: 4] >= 4'd5) begin
        corrected[WIDTH + 4*k +: 4] = sh[WIDTH + 4*k +: 4] + 4'd3;
      end
    end
    shifted = corrected << 1;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh    <= {BCD_W'(0), bin};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sh  <= shifted;
          cnt <= cnt + CNT_W'(1);
          // Last iteration: publish the post-shift scratch digits.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bcd   <= shifted[SH_W-1:WIDTH];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq with a decimal-arithmetic model.
module tb_bcd_convert_seq;

  logic        clk;
  logic        RESET;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int checks = 0;
  int errors = 0;

  bcd_convert_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .RESET (RESET),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and wait (bounded) for done.
  task automatic do_convert(input logic [15:0] v, output logic [19:0] res,
                            output int lat, output int busy_n, output bit held);
    logic [19:0] prev;
    prev   = bcd;
    held   = 1'b1;
    bin    = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (bcd !== prev) held = 1'b0;
      tick();
      lat++;
    end
    res = bcd;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, expected 0 0 00000", busy, done, bcd);
    end
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b bcd=%h, expected 0 0 00000", i, busy, done, bcd);
      end
    end
  endtask

  task automatic test_basic();
    logic [19:0] res;
    int lat, bn;
    bit held;
    do_convert(16'd255, res, lat, bn, held);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL basic_latency: got %0d, expected 16", lat);
    end
    checks++;
    if (bn !== 16) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, expected 16", bn);
    end
    checks++;
    if (res !== 20'h00255) begin
      errors++;
      $display("FAIL basic_result: got %h, expected 00255", res);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL basic_bcd_held: bcd changed while busy");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== 20'h00255) begin
        errors++;
        $display("FAIL basic_hold[%0d]: done=%b busy=%b bcd=%h, expected 0 0 00255", i, done, busy, bcd);
      end
    end
  endtask

  task automatic test_values();
    logic [15:0] vals [5] = '{16'd0, 16'd9, 16'd10, 16'd65535, 16'd40960};
    logic [15:0] v;
    logic [19:0] res;
    int lat, bn;
    bit held;
    for (int i = 0; i < 25; i++) begin
      v = (i < 5) ? vals[i] : 16'($urandom_range(0, 65535));
      do_convert(v, res, lat, bn, held);
      checks++;
      if (res !== to_bcd(int'(v)) || lat !== 16 || held !== 1'b1) begin
        errors++;
        $display("FAIL value bin=%0d: bcd=%h lat=%0d held=%b, expected bcd=%h lat=16 held=1",
                 v, res, lat, held, to_bcd(int'(v)));
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL value_done_pulse bin=%0d: done=%b, expected 0", v, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, ndone;
    logic [19:0] prev;
    prev  = bcd;
    bin   = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
    end
    bin   = 16'd9999;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || bcd !== prev) begin
      errors++;
      $display("FAIL ignore_midconv: busy=%b bcd=%h, expected 1 %h", busy, bcd, prev);
    end
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 16 || bcd !== 20'h01234) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d bcd=%h, expected 16 01234", lat, bcd);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0 || bcd !== 20'h01234) begin
      errors++;
      $display("FAIL ignore_extra_done: extra=%0d busy=%b bcd=%h, expected 0 0 01234", ndone, busy, bcd);
    end
  endtask

  task automatic test_back_to_back();
    int tdone [3];
    logic [19:0] rdone [3];
    logic [15:0] exp_bin [3];
    int n;
    exp_bin[0] = 16'd100;
    exp_bin[1] = 16'd200;
    exp_bin[2] = 16'($urandom_range(0, 65535));
    n = 0;
    bin   = exp_bin[0];
    start = 1'b1;
    tick();
    bin = exp_bin[1];
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (done === 1'b1) begin
        if (n < 3) begin
          tdone[n] = t;
          rdone[n] = bcd;
        end
        n++;
        if (n == 2) bin = exp_bin[2];
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, expected 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tdone[i] !== 16 + 17*i || rdone[i] !== to_bcd(int'(exp_bin[i]))) begin
          errors++;
          $display("FAIL b2b[%0d]: t=%0d bcd=%h, expected t=%0d bcd=%h",
                   i, tdone[i], rdone[i], 16 + 17*i, to_bcd(int'(exp_bin[i])));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [19:0] res;
    int lat, bn, ndone;
    bit held;
    do_convert(16'd42, res, lat, bn, held);
    checks++;
    if (res !== 20'h00042) begin
      errors++;
      $display("FAIL abort_pre: bcd=%h, expected 00042", res);
    end
    tick();
    bin   = 16'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (busy !== 1'b1 || bcd !== 20'h00042) begin
      errors++;
      $display("FAIL abort_midconv: busy=%b bcd=%h, expected 1 00042", busy, bcd);
    end
    RESET = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b bcd=%h, expected 0 0 00000", busy, done, bcd);
    end
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL abort_no_done: activity=%0d bcd=%h, expected 0 00000", ndone, bcd);
    end
    do_convert(16'd777, res, lat, bn, held);
    checks++;
    if (res !== 20'h00777 || lat !== 16) begin
      errors++;
      $display("FAIL abort_recover: bcd=%h lat=%0d, expected 00777 16", res, lat);
    end
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    bin   = '0;
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    tick();
    test_back_to_back();
    tick();
    tick();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
